// File: rtl/dp_ctrl_pkg.sv
// Shared definitions for the dp_unit job sequencer.
//   dp_state_e       : FSM state names (IDLE, CLEAR, STREAM, DRAIN, DONE)
//   ST_*             : the same encodings as plain logic constants for the state register
//   DP_VALID_BOTH/NONE : dp_in_valid codes for a full beat / no beat
package dp_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } dp_state_e;

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_CLEAR  = CLEAR;
    localparam logic [2:0] ST_STREAM = STREAM;
    localparam logic [2:0] ST_DRAIN  = DRAIN;
    localparam logic [2:0] ST_DONE   = DONE;

    localparam logic [1:0] DP_VALID_BOTH = 2'b11;
    localparam logic [1:0] DP_VALID_NONE = 2'b00;

endpackage

// File: rtl/dp_seq_ctrl_if.sv
// Bundle of all sequencer-facing signals except clk/reset.
//   job_*      : job request from the tile scheduler (valid/ready, length, operand masks)
//   rd_*       : operand buffer read port (1-cycle read latency)
//   dp_*       : dp_unit control, operand beat and accumulator return
//   res_*      : result valid/ready port
//   busy       : sequencer not idle
// Modport master is the sequencer; modport slave is its environment.
interface dp_seq_ctrl_if #(
    parameter int unsigned DW_DATA = 8,
    parameter int unsigned VEC_LEN = 16
);
    localparam int unsigned AW = $clog2(VEC_LEN);

    logic               job_valid;
    logic               job_ready;
    logic [AW:0]        job_len;
    logic [VEC_LEN-1:0] job_mask_a;
    logic [VEC_LEN-1:0] job_mask_b;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic [DW_DATA-1:0] rd_data_a;
    logic [DW_DATA-1:0] rd_data_b;
    logic               dp_reset;
    logic               dp_enable;
    logic [DW_DATA-1:0] dp_in_a;
    logic [DW_DATA-1:0] dp_in_b;
    logic [1:0]         dp_in_valid;
    logic [DW_DATA-1:0] dp_out;
    logic               res_valid;
    logic               res_ready;
    logic [DW_DATA-1:0] res_data;
    logic               busy;

    modport master (
        input  job_valid, job_len, job_mask_a, job_mask_b,
        input  rd_data_a, rd_data_b, dp_out, res_ready,
        output job_ready, rd_en, rd_addr, dp_reset, dp_enable,
        output dp_in_a, dp_in_b, dp_in_valid, res_valid, res_data, busy
    );

    modport slave (
        output job_valid, job_len, job_mask_a, job_mask_b,
        output rd_data_a, rd_data_b, dp_out, res_ready,
        input  job_ready, rd_en, rd_addr, dp_reset, dp_enable,
        input  dp_in_a, dp_in_b, dp_in_valid, res_valid, res_data, busy
    );

endinterface

// File: rtl/dp_skip_pe.sv
// Priority encoder for zero-skip streaming: finds the lowest set bit of mask
// strictly above idx and strictly below len. Purely combinational.
//   mask     : in  VEC_LEN  candidate elements (mask_a & mask_b)
//   len      : in  AW+1     job length bound
//   idx      : in  AW       current element index
//   next_idx : out AW       lowest qualifying index (0 when none)
//   found    : out 1        a qualifying index exists
module dp_skip_pe #(
    parameter int unsigned VEC_LEN = 16,
    localparam int unsigned AW = $clog2(VEC_LEN)
) (
    input  logic [VEC_LEN-1:0] mask,
    input  logic [AW:0]        len,
    input  logic [AW-1:0]      idx,
    output logic [AW-1:0]      next_idx,
    output logic               found
);

    // Scan downward so the lowest qualifying bit is the last one written.
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        for (int i = int'(VEC_LEN) - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(idx)) && (i < int'(len))) begin
                next_idx = AW'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dp_seq_ctrl.sv
// Job sequencer for one dp_unit dot-product lane: accepts a job, clears the lane,
// streams operand pairs from the operand buffers, waits out the lane latency and
// returns the captured accumulator on a valid/ready result port.
//   clk   : in  clock
//   reset : in  synchronous active-high reset
//   bus   : dp_seq_ctrl_if.master (job, operand read, dp_unit, result and busy signals)
// Build option: define DP_SEQ_ZERO_SKIP_EN to issue only indices where both
// operands are nonzero (mask_a & mask_b) instead of every index below len.
module dp_seq_ctrl
    import dp_ctrl_pkg::*;
#(
    parameter int unsigned DW_DATA = 8,
    parameter int unsigned VEC_LEN = 16,
    parameter int unsigned DP_LAT  = 2
) (
    input  logic          clk,
    input  logic          reset,
    dp_seq_ctrl_if.master bus
);

    localparam int unsigned AW = $clog2(VEC_LEN);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = (DP_LAT < 1) ? 1 : $clog2(DP_LAT + 1);

    logic [2:0]         state, state_next;
    logic [AW-1:0]      idx, idx_next;
    logic [CW-1:0]      cnt, cnt_next;
    logic [LW-1:0]      len_q, len_in;
    logic [VEC_LEN-1:0] mask_a_q, mask_b_q;
    logic [1:0]         pipe_valid;
    logic [DW_DATA-1:0] res_q;
    logic               job_ready_q, busy_q, rd_en_q, dp_reset_q, dp_enable_q, res_valid_q;

    // Index-walk decisions, supplied by the selected streaming policy.
    logic               none_to_issue;
    logic [AW-1:0]      first_idx;
    logic               last_issue;
    logic [AW-1:0]      next_issue;
    logic [1:0]         beat_valid;

    assign len_in = (bus.job_len > LW'(VEC_LEN)) ? LW'(VEC_LEN) : bus.job_len;

`ifdef DP_SEQ_ZERO_SKIP_EN
    logic [VEC_LEN-1:0] both_nz;
    logic [AW-1:0]      pe_next;
    logic               pe_found;
    logic               first_is_zero;

    assign both_nz = mask_a_q & mask_b_q;

    dp_skip_pe #(.VEC_LEN(VEC_LEN)) u_skip_pe (
        .mask     (both_nz),
        .len      (len_q),
        .idx      (idx),
        .next_idx (pe_next),
        .found    (pe_found)
    );

    // idx is 0 in CLEAR, so element 0 is tested directly and the encoder covers the rest.
    assign first_is_zero = both_nz[0] && (len_q != '0);
    assign none_to_issue = !(first_is_zero || pe_found);
    assign first_idx     = first_is_zero ? '0 : pe_next;
    assign last_issue    = !pe_found;
    assign next_issue    = pe_next;
    assign beat_valid    = DP_VALID_BOTH;
`else
    assign none_to_issue = (len_q == '0);
    assign first_idx     = '0;
    assign last_issue    = (LW'(idx) == (len_q - LW'(1)));
    assign next_issue    = idx + AW'(1);
    assign beat_valid    = {mask_a_q[idx], mask_b_q[idx]};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state, index and drain-counter logic.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (bus.job_valid && job_ready_q) begin
                    state_next = ST_CLEAR;
                    idx_next   = '0;
                end
            end
            ST_CLEAR: begin
                if (none_to_issue) begin
                    state_next = ST_DRAIN;
                    cnt_next   = CW'(DP_LAT);
                end else begin
                    state_next = ST_STREAM;
                    idx_next   = first_idx;
                end
            end
            ST_STREAM: begin
                if (last_issue) begin
                    state_next = ST_DRAIN;
                    cnt_next   = CW'(DP_LAT);
                end else begin
                    idx_next   = next_issue;
                end
            end
            ST_DRAIN: begin
                if (cnt == '0) state_next = ST_DONE;
                else           cnt_next   = cnt - CW'(1);
            end
            ST_DONE: begin
                if (bus.res_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Job fields, beat pipe stage, result capture and registered state-decoded outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            cnt         <= '0;
            len_q       <= '0;
            mask_a_q    <= '0;
            mask_b_q    <= '0;
            pipe_valid  <= DP_VALID_NONE;
            res_q       <= '0;
            job_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            dp_reset_q  <= 1'b0;
            dp_enable_q <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            idx <= idx_next;
            cnt <= cnt_next;
            if (state == ST_IDLE && bus.job_valid && job_ready_q) begin
                len_q    <= len_in;
                mask_a_q <= bus.job_mask_a;
                mask_b_q <= bus.job_mask_b;
            end
            // Beat lines up with the operand buffer's 1-cycle read latency.
            pipe_valid <= (state == ST_STREAM) ? beat_valid : DP_VALID_NONE;
            if (state == ST_DRAIN && cnt == '0) res_q <= bus.dp_out;
            job_ready_q <= (state_next == ST_IDLE);
            busy_q      <= (state_next != ST_IDLE);
            rd_en_q     <= (state_next == ST_STREAM);
            dp_reset_q  <= (state_next == ST_CLEAR);
            dp_enable_q <= (state_next == ST_STREAM) || (state_next == ST_DRAIN);
            res_valid_q <= (state_next == ST_DONE);
        end
    end

    assign bus.job_ready   = job_ready_q;
    assign bus.busy        = busy_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.rd_addr     = idx;
    assign bus.dp_reset    = dp_reset_q;
    assign bus.dp_enable   = dp_enable_q;
    assign bus.dp_in_valid = pipe_valid;
    // Read data arrives this cycle, so operands are gated rather than re-registered.
    assign bus.dp_in_a     = (pipe_valid == DP_VALID_BOTH) ? bus.rd_data_a : '0;
    assign bus.dp_in_b     = (pipe_valid == DP_VALID_BOTH) ? bus.rd_data_b : '0;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_q;

endmodule

// File: tb/tb_dp_seq_ctrl.sv
// Self-checking bench for dp_seq_ctrl: operand buffers and a simple accumulating
// lane surround the DUT; expected results, read order, beat codes and latency
// come from a per-job reference built from the job description.
module tb_dp_seq_ctrl;

    localparam int unsigned DW  = 8;
    localparam int unsigned VL  = 16;
    localparam int unsigned LAT = 2;
`ifdef DP_SEQ_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dp_seq_ctrl_if #(.DW_DATA(DW), .VEC_LEN(VL)) bus ();

    dp_seq_ctrl #(.DW_DATA(DW), .VEC_LEN(VL), .DP_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Operand buffers with 1-cycle read latency.
    logic [7:0] mem_a [VL];
    logic [7:0] mem_b [VL];
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data_a <= mem_a[bus.rd_addr];
            bus.rd_data_b <= mem_b[bus.rd_addr];
        end
    end

    // Lane: clears on dp_reset, accumulates on full beats, wraps at 8 bits.
    logic [7:0] acc;
    always @(posedge clk) begin
        if (reset || bus.dp_reset) acc <= 8'd0;
        else if (bus.dp_enable && bus.dp_in_valid == 2'b11) acc <= acc + 8'(bus.dp_in_a * bus.dp_in_b);
    end
    assign bus.dp_out = acc;

    // Monitor: records reads and beats, checks operand gating every cycle.
    int         addr_q[$];
    logic [1:0] beat_q[$];
    int         rst_pulses;
    bit         pend = 1'b0;
    int         pend_addr = 0;
    always @(posedge clk) begin
        #1;
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                beat_q.push_back(bus.dp_in_valid);
                if (bus.dp_in_valid == 2'b11) begin
                    check("opnd_a", 32'(bus.dp_in_a), 32'(mem_a[pend_addr]));
                    check("opnd_b", 32'(bus.dp_in_b), 32'(mem_b[pend_addr]));
                end else begin
                    check("opnd_gate", 32'({bus.dp_in_a, bus.dp_in_b}), 32'd0);
                end
            end else begin
                check("no_beat", 32'({bus.dp_in_valid, bus.dp_in_a, bus.dp_in_b}), 32'd0);
            end
            if (bus.dp_reset) rst_pulses++;
            pend      = bus.rd_en;
            pend_addr = int'(bus.rd_addr);
            if (bus.rd_en) addr_q.push_back(int'(bus.rd_addr));
        end
    end

    int accept_cyc, hs_cyc;

    task automatic rand_mem();
        for (int i = 0; i < int'(VL); i++) begin
            mem_a[i] = 8'($urandom);
            mem_b[i] = 8'($urandom);
        end
    endtask

    // Runs one job end to end; stall = cycles res_ready is held low in DONE,
    // keep = leave job_valid asserted through the handshake.
    task automatic run_job(input int len, input logic [15:0] ma, input logic [15:0] mb,
                           input int stall, input bit keep);
        int         exp_addr[$];
        logic [1:0] exp_beat[$];
        int         sum = 0;
        int         lim;
        int         n;
        int         exp_lat;
        logic [7:0] exp_res;
        lim = (len > int'(VL)) ? int'(VL) : len;
        for (int i = 0; i < lim; i++) begin
            if (ma[i] && mb[i]) sum += int'($signed(mem_a[i])) * int'($signed(mem_b[i]));
            if (!SKIP || (ma[i] && mb[i])) begin
                exp_addr.push_back(i);
                exp_beat.push_back({ma[i], mb[i]});
            end
        end
        exp_res = 8'(sum);
        exp_lat = 1 + exp_addr.size() + 1 + int'(LAT);

        bus.job_len    = 5'(len);
        bus.job_mask_a = ma;
        bus.job_mask_b = mb;
        bus.job_valid  = 1'b1;
        addr_q.delete();
        beat_q.delete();
        rst_pulses = 0;

        n = 0;
        while (!bus.job_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("job_ready", 32'(bus.job_ready), 32'd1);
        if (!bus.job_ready) begin
            bus.job_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        if (!keep) bus.job_valid = 1'b0;
        check("busy_accept", 32'({bus.busy, bus.job_ready}), 32'b10);

        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.res_valid && n < 300);
        check("latency", 32'(n), 32'(exp_lat));
        if (!bus.res_valid) return;
        check("res_data", 32'(bus.res_data), 32'(exp_res));
        check("dp_reset_pulses", 32'(rst_pulses), 32'd1);
        check("n_reads", 32'(addr_q.size()), 32'(exp_addr.size()));
        check("n_beats", 32'(beat_q.size()), 32'(exp_beat.size()));
        for (int i = 0; i < exp_addr.size() && i < addr_q.size(); i++)
            check("rd_addr", 32'(addr_q[i]), 32'(exp_addr[i]));
        for (int i = 0; i < exp_beat.size() && i < beat_q.size(); i++)
            check("dp_in_valid", 32'(beat_q[i]), 32'(exp_beat[i]));

        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_res_valid", 32'(bus.res_valid), 32'd1);
            check("stall_res_data", 32'(bus.res_data), 32'(exp_res));
            check("stall_job_ready", 32'(bus.job_ready), 32'd0);
            bus.job_valid = keep || (i == 1);
        end

        @(negedge clk);
        bus.res_ready = 1'b1;
        bus.job_valid = keep;
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        check("hs_res_valid", 32'(bus.res_valid), 32'd0);
        check("hs_job_ready", 32'(bus.job_ready), 32'd1);
        @(negedge clk);
        bus.res_ready = 1'b0;
        if (!keep) check("stay_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int h;
        reset          = 1'b1;
        bus.job_valid  = 1'b0;
        bus.job_len    = '0;
        bus.job_mask_a = '0;
        bus.job_mask_b = '0;
        bus.res_ready  = 1'b0;
        for (int i = 0; i < int'(VL); i++) begin
            mem_a[i] = 8'd0;
            mem_b[i] = 8'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_job_ready", 32'(bus.job_ready), 32'd1);
        check("rst_outputs", 32'({bus.busy, bus.rd_en, bus.dp_reset, bus.dp_enable,
                                  bus.res_valid, bus.dp_in_valid, bus.res_data}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Dense job and masked beat on the reference vectors.
        mem_a[0] = 8'd2;   mem_a[1] = 8'd1; mem_a[2] = 8'd1; mem_a[3] = 8'd2;
        mem_b[0] = 8'hFE;  mem_b[1] = 8'd1; mem_b[2] = 8'd1; mem_b[3] = 8'd2;
        run_job(4, 16'h000F, 16'h000F, 0, 1'b0);
        run_job(4, 16'h000F, 16'h000B, 0, 1'b0);
        // Empty job.
        run_job(0, 16'hFFFF, 16'hFFFF, 0, 1'b0);
        // Result backpressure with an ignored job request.
        run_job(4, 16'h000F, 16'h000F, 5, 1'b0);

        // Reset in the middle of a len=8 stream, then a fresh job.
        rand_mem();
        bus.job_len    = 5'd8;
        bus.job_mask_a = 16'hFFFF;
        bus.job_mask_b = 16'hFFFF;
        bus.job_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.job_valid = 1'b0;
        n = 0;
        while (!(bus.rd_en && bus.rd_addr == 4'd2) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_beat2", 32'(bus.rd_en && bus.rd_addr == 4'd2), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_job_ready", 32'(bus.job_ready), 32'd1);
        check("mid_rst_ctrl", 32'({bus.busy, bus.rd_en, bus.rd_addr, bus.dp_reset,
                                   bus.dp_enable, bus.res_valid}), 32'd0);
        check("mid_rst_data", 32'({bus.dp_in_valid, bus.dp_in_a, bus.dp_in_b, bus.res_data}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_job(8, 16'($urandom), 16'($urandom), 0, 1'b0);

        // Back-to-back full-length jobs with job_valid held.
        rand_mem();
        run_job(16, 16'hFFFF, 16'hFFFF, 0, 1'b1);
        h = hs_cyc;
        run_job(16, 16'hFFFF, 16'hFFFF, 0, 1'b0);
        check("b2b_gap", 32'(accept_cyc - h), 32'd1);

        // Randomized jobs, including lengths beyond VEC_LEN.
        for (int k = 0; k < 30; k++) begin
            logic [15:0] ma, mb;
            rand_mem();
            ma = 16'($urandom);
            mb = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            run_job(int'($urandom_range(0, 20)), ma, mb, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
